score_keeper: RTL and testbench
===============================

# score_keeper

Match score state machine for augmented-reality pong. Samples the ball position once per video frame, detects goal-line crossings, and keeps both players' scores as 4-bit decimal digits 0–9. Holds the ball frozen for a serve holdoff after each point and declares a winner at the target score. Sits directly upstream of the per-player score digit renderers, which consume `score_p1` and `score_p2`, and alongside the ball logic, which consumes `ball_freeze`, `serve_req` and `serve_dir`.

## Interface
- `WIN_SCORE`, 4'd9: score that ends the game; legal range 1–9.
- `HOLDOFF_FRAMES`, 8'd120: frames the ball stays frozen before a serve; legal range 1–255.
- `LEFT_GOAL_COL`, 13'd8: ball column at or below which player 1 has missed.
- `RIGHT_GOAL_COL`, 13'd631: ball column at or above which player 2 has missed.

- `clk`  in  1  pixel/system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per frame (end of active video).
- `ball_col`  in  13  ball column, stable while `frame_tick` is high.
- `restart`  in  1  one-cycle pulse: clear the match.
- `score_p1`  out  4  player 1 score, 0..WIN_SCORE.
- `score_p2`  out  4  player 2 score, 0..WIN_SCORE.
- `point_p1`, `point_p2`  out  1 each  one-cycle pulse when that player scores.
- `ball_freeze`  out  1  high while not in PLAY.
- `serve_req`  out  1  one-cycle pulse: ball logic re-centres and launches.
- `serve_dir`  out  1  0 = serve toward player 1 (left), 1 = toward player 2.
- `game_over`  out  1  high in GAME_OVER.
- `winner`  out  1  0 = player 1, 1 = player 2; valid while `game_over` is high.

## Operation
- The FSM has three states: HOLDOFF, PLAY and GAME_OVER.
- 8-bit frame counter `hold_cnt`, advanced only on `frame_tick`.
- **HOLDOFF:** on each `frame_tick`, `hold_cnt` increments. When the increment makes it equal to HOLDOFF_FRAMES:
  - pulse `serve_req`;
  - clear `hold_cnt`;
  - go to PLAY.
- HOLDOFF ignores goal crossings.
- **PLAY, on `frame_tick`:**
  - `ball_col <= LEFT_GOAL_COL`: player 2 scores. Increment `score_p2`, pulse `point_p2`, set `serve_dir` = 0.
  - Else `ball_col >= RIGHT_GOAL_COL`: player 1 scores. Increment `score_p1`, pulse `point_p1`, set `serve_dir` = 1.
  - If both comparisons are true (misconfigured goals), the left check wins.
  - After scoring: if the new score equals WIN_SCORE, go to GAME_OVER, set `winner`, and raise `game_over`. Otherwise go to HOLDOFF with `hold_cnt` = 0.
- **GAME_OVER:** scores are frozen and goal crossings are ignored. Exit is by `restart`, or by the auto-restart described under Configuration.
- **`restart`, in any state:**
  - clear both scores, `game_over`, `winner` and `hold_cnt`;
  - set `serve_dir` = 0;
  - go to HOLDOFF.
  - `restart` takes priority over a goal or a holdoff expiry in the same cycle; no point pulse and no `serve_req` are issued.
- Scores never exceed WIN_SCORE and never wrap.
- `ball_freeze` is high in the HOLDOFF and GAME_OVER states.

## Timing
- Reset values:
  - state HOLDOFF, `hold_cnt` 0;
  - both scores 0;
  - `point_p1`, `point_p2`, `serve_req`, `game_over`, `winner`, `serve_dir` all 0;
  - `ball_freeze` 1.
- The first serve occurs HOLDOFF_FRAMES frame ticks after reset is released.
- All outputs are registered. Score, point pulse, state, `game_over` and `ball_freeze` change in the cycle after the sampling `frame_tick`, which is 1-cycle latency.
- `serve_req` is high exactly one cycle, the cycle after the HOLDOFF_FRAMES-th tick. `ball_freeze` falls in that same cycle.
- `frame_tick` held high for more than one cycle is treated as multiple ticks; upstream guarantees single-cycle pulses.
- `reset_n` asserted mid-frame or mid-holdoff forces all reset values immediately (asynchronous).

## Configuration
- `SCORE_AUTO_RESTART_EN` defined: in GAME_OVER, `hold_cnt` counts frame ticks. On reaching HOLDOFF_FRAMES, the block performs the same actions as `restart`, so scores display the final result for HOLDOFF_FRAMES frames.
- `SCORE_AUTO_RESTART_EN` undefined: GAME_OVER is held indefinitely until `restart`; `hold_cnt` stays 0.

## Test plan
- **Reset and first serve:** release reset with HOLDOFF_FRAMES=3 and issue 3 `frame_tick`s. Required: scores 0, `ball_freeze`=1, and `serve_req` pulses exactly once, one cycle after the 3rd tick. `ball_freeze` then goes to 0.
- **Goal detection:** in PLAY, `frame_tick` with `ball_col`=5. Required: next cycle `score_p2`=1, `point_p2` pulses once, `serve_dir`=0, `ball_freeze`=1. During the following holdoff, a `ball_col`=635 tick leaves `score_p1`=0.
- **Win:** drive player 1 to 9 goals (`ball_col`=640) with `WIN_SCORE`=9. Required: `score_p1`=9, `game_over`=1, `winner`=0. Further ticks with `ball_col`=0 leave `score_p2` unchanged.
- **Restart priority:** assert `restart` in the same cycle as a PLAY `frame_tick` with `ball_col`=0. Required: both scores 0, no `point_p2`, state HOLDOFF, `game_over`=0.
- **Mid-holdoff reset:** assert `reset_n`=0 mid-holdoff with `score_p1`=4. Required: all outputs take reset values immediately, without waiting for a clock edge.
- **Auto-restart:** with `SCORE_AUTO_RESTART_EN` and HOLDOFF_FRAMES=2, reach GAME_OVER and issue 2 ticks. Required: scores clear and `game_over`=0. Without the macro, 10 ticks leave `game_over`=1.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: match score state machine for augmented-reality pong.
// Samples the ball column once per frame, awards points on goal-line
// crossings, freezes the ball for a serve holdoff after each point and
// declares a winner when a player reaches WIN_SCORE.
// Optional feature: define SCORE_AUTO_RESTART_EN to make GAME_OVER clear
// itself after HOLDOFF_FRAMES frame ticks. Without it, GAME_OVER holds
// until restart.
module score_keeper #(
    parameter logic [3:0]  WIN_SCORE      = 4'd9,
    parameter logic [7:0]  HOLDOFF_FRAMES = 8'd120,
    parameter logic [12:0] LEFT_GOAL_COL  = 13'd8,
    parameter logic [12:0] RIGHT_GOAL_COL = 13'd631
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic [12:0] ball_col,
    input  logic        restart,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic        point_p1,
    output logic        point_p2,
    output logic        ball_freeze,
    output logic        serve_req,
    output logic        serve_dir,
    output logic        game_over,
    output logic        winner
);

    typedef enum logic [1:0] {
        ST_HOLDOFF   = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  score_p1_q, score_p1_d;
    logic [3:0]  score_p2_q, score_p2_d;
    logic        point_p1_q, point_p1_d;
    logic        point_p2_q, point_p2_d;
    logic        serve_req_q, serve_req_d;
    logic        serve_dir_q, serve_dir_d;
    logic        game_over_q, game_over_d;
    logic        winner_q, winner_d;
    logic        ball_freeze_q, ball_freeze_d;

    // Pre-computed increments keep the next-state logic readable.
    logic [7:0]  hold_cnt_inc;
    logic [3:0]  score_p1_inc;
    logic [3:0]  score_p2_inc;

    assign hold_cnt_inc = hold_cnt_q + 8'd1;
    assign score_p1_inc = score_p1_q + 4'd1;
    assign score_p2_inc = score_p2_q + 4'd1;

    // Next-state and registered-output logic; restart overrides everything.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        score_p1_d    = score_p1_q;
        score_p2_d    = score_p2_q;
        point_p1_d    = 1'b0;
        point_p2_d    = 1'b0;
        serve_req_d   = 1'b0;
        serve_dir_d   = serve_dir_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;

        if (restart) begin
            state_d     = ST_HOLDOFF;
            hold_cnt_d  = 8'd0;
            score_p1_d  = 4'd0;
            score_p2_d  = 4'd0;
            serve_dir_d = 1'b0;
            game_over_d = 1'b0;
            winner_d    = 1'b0;
        end else if (frame_tick) begin
            case (state_q)
                ST_HOLDOFF: begin
                    // Goal crossings are ignored while the ball is frozen.
                    if (hold_cnt_inc == HOLDOFF_FRAMES) begin
                        serve_req_d = 1'b1;
                        hold_cnt_d  = 8'd0;
                        state_d     = ST_PLAY;
                    end else begin
                        hold_cnt_d  = hold_cnt_inc;
                    end
                end
                ST_PLAY: begin
                    // Left goal is checked first so a misconfigured overlap
                    // still awards exactly one point.
                    if (ball_col <= LEFT_GOAL_COL) begin
                        point_p2_d  = 1'b1;
                        serve_dir_d = 1'b0;
                        hold_cnt_d  = 8'd0;
                        if (score_p2_inc >= WIN_SCORE) begin
                            score_p2_d  = WIN_SCORE;
                            state_d     = ST_GAME_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                        end else begin
                            score_p2_d  = score_p2_inc;
                            state_d     = ST_HOLDOFF;
                        end
                    end else if (ball_col >= RIGHT_GOAL_COL) begin
                        point_p1_d  = 1'b1;
                        serve_dir_d = 1'b1;
                        hold_cnt_d  = 8'd0;
                        if (score_p1_inc >= WIN_SCORE) begin
                            score_p1_d  = WIN_SCORE;
                            state_d     = ST_GAME_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                        end else begin
                            score_p1_d  = score_p1_inc;
                            state_d     = ST_HOLDOFF;
                        end
                    end
                end
                ST_GAME_OVER: begin
`ifdef SCORE_AUTO_RESTART_EN
                    // Show the final result for a holdoff, then clear.
                    if (hold_cnt_inc == HOLDOFF_FRAMES) begin
                        state_d     = ST_HOLDOFF;
                        hold_cnt_d  = 8'd0;
                        score_p1_d  = 4'd0;
                        score_p2_d  = 4'd0;
                        serve_dir_d = 1'b0;
                        game_over_d = 1'b0;
                        winner_d    = 1'b0;
                    end else begin
                        hold_cnt_d  = hold_cnt_inc;
                    end
`else
                    // Held until an explicit restart.
                    hold_cnt_d = 8'd0;
`endif
                end
                default: begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = 8'd0;
                end
            endcase
        end

        // Registered so it falls together with the serve_req pulse.
        ball_freeze_d = (state_d != ST_PLAY);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HOLDOFF;
            hold_cnt_q    <= 8'd0;
            score_p1_q    <= 4'd0;
            score_p2_q    <= 4'd0;
            point_p1_q    <= 1'b0;
            point_p2_q    <= 1'b0;
            serve_req_q   <= 1'b0;
            serve_dir_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            ball_freeze_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            score_p1_q    <= score_p1_d;
            score_p2_q    <= score_p2_d;
            point_p1_q    <= point_p1_d;
            point_p2_q    <= point_p2_d;
            serve_req_q   <= serve_req_d;
            serve_dir_q   <= serve_dir_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            ball_freeze_q <= ball_freeze_d;
        end
    end

    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign point_p1    = point_p1_q;
    assign point_p2    = point_p2_q;
    assign ball_freeze = ball_freeze_q;
    assign serve_req   = serve_req_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper. A behavioural match model predicts the
// outputs for every driven cycle; predictions are queued when stimulus is
// applied and popped/compared one cycle later. Build with
// SCORE_AUTO_RESTART_EN defined to exercise the auto-restart variant.
module tb_score_keeper;

`ifdef SCORE_AUTO_RESTART_EN
    localparam int HF = 2;
`else
    localparam int HF = 3;
`endif
    localparam int WS    = 9;
    localparam int LEFT  = 8;
    localparam int RIGHT = 631;

    localparam int M_HOLD = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [12:0] ball_col = 13'd320;
    logic        restart = 1'b0;
    logic [3:0]  score_p1, score_p2;
    logic        point_p1, point_p2, ball_freeze, serve_req, serve_dir;
    logic        game_over, winner;

    score_keeper #(
        .WIN_SCORE     (4'(WS)),
        .HOLDOFF_FRAMES(8'(HF)),
        .LEFT_GOAL_COL (13'(LEFT)),
        .RIGHT_GOAL_COL(13'(RIGHT))
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .ball_col   (ball_col),
        .restart    (restart),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .point_p1   (point_p1),
        .point_p2   (point_p2),
        .ball_freeze(ball_freeze),
        .serve_req  (serve_req),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s1; int s2; int p1; int p2; int frz; int sreq; int dir; int over; int win;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int serve_seen = 0;

    // Behavioural match model
    int m_state = M_HOLD;
    int m_cnt = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_dir = 0;
    int m_over = 0;
    int m_win = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        m_state = M_HOLD; m_cnt = 0; m_s1 = 0; m_s2 = 0;
        m_dir = 0; m_over = 0; m_win = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s1"},   int'(score_p1), 0);
        check({tag, "_s2"},   int'(score_p2), 0);
        check({tag, "_p1"},   int'(point_p1), 0);
        check({tag, "_p2"},   int'(point_p2), 0);
        check({tag, "_sreq"}, int'(serve_req), 0);
        check({tag, "_dir"},  int'(serve_dir), 0);
        check({tag, "_over"}, int'(game_over), 0);
        check({tag, "_win"},  int'(winner), 0);
        check({tag, "_frz"},  int'(ball_freeze), 1);
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input string tag, input logic tk, input int col, input logic rs);
        exp_t e;
        frame_tick = tk;
        ball_col   = 13'(col);
        restart    = rs;
        e.p1 = 0; e.p2 = 0; e.sreq = 0;
        if (rs) begin
            model_clear();
        end else if (tk) begin
            case (m_state)
                M_HOLD: begin
                    m_cnt++;
                    if (m_cnt == HF) begin
                        e.sreq = 1; m_cnt = 0; m_state = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (col <= LEFT) begin
                        m_s2++; e.p2 = 1; m_dir = 0;
                        if (m_s2 == WS) begin m_state = M_OVER; m_over = 1; m_win = 1; end
                        else begin m_state = M_HOLD; m_cnt = 0; end
                    end else if (col >= RIGHT) begin
                        m_s1++; e.p1 = 1; m_dir = 1;
                        if (m_s1 == WS) begin m_state = M_OVER; m_over = 1; m_win = 0; end
                        else begin m_state = M_HOLD; m_cnt = 0; end
                    end
                end
                default: begin
`ifdef SCORE_AUTO_RESTART_EN
                    m_cnt++;
                    if (m_cnt == HF) model_clear();
`endif
                end
            endcase
        end
        e.s1 = m_s1; e.s2 = m_s2; e.dir = m_dir; e.over = m_over; e.win = m_win;
        e.frz = (m_state != M_PLAY) ? 1 : 0;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        restart    = 1'b0;
        if (serve_req) serve_seen++;

        check({tag, "_qlen"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_s1"},   int'(score_p1),    e.s1);
            check({tag, "_s2"},   int'(score_p2),    e.s2);
            check({tag, "_p1"},   int'(point_p1),    e.p1);
            check({tag, "_p2"},   int'(point_p2),    e.p2);
            check({tag, "_frz"},  int'(ball_freeze), e.frz);
            check({tag, "_sreq"}, int'(serve_req),   e.sreq);
            check({tag, "_dir"},  int'(serve_dir),   e.dir);
            check({tag, "_over"}, int'(game_over),   e.over);
            check({tag, "_win"},  int'(winner),      e.win);
        end
        $display("step %-8s tick=%0d col=%0d rst=%0d -> s1=%0d s2=%0d frz=%0d sreq=%0d over=%0d",
                 tag, tk, col, rs, score_p1, score_p2, ball_freeze, serve_req, game_over);
    endtask

    // Tick through holdoff (with idle gaps) until the model reaches PLAY.
    task automatic serve(input string tag);
        for (int i = 0; i < 300 && m_state == M_HOLD; i++) begin
            step(tag, 1'b0, 320, 1'b0);
            step(tag, 1'b1, 320, 1'b0);
        end
        check({tag, "_inplay"}, m_state, M_PLAY);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        // First serve: exactly one serve_req after the HF-th tick
        serve_seen = 0;
        serve("first");
        check("first_serve_count", serve_seen, 1);
        step("idle", 1'b0, 320, 1'b0);

        // Goal on the left; right-goal tick during holdoff is ignored
        step("goal_l", 1'b1, 5, 1'b0);
        check("goal_l_s2", int'(score_p2), 1);
        step("hold_ign", 1'b1, 635, 1'b0);
        check("hold_ign_s1", int'(score_p1), 0);
        serve("serve2");

        // Exact boundary columns: LEFT scores for p2, RIGHT for p1
        step("bnd_l", 1'b1, LEFT, 1'b0);
        serve("serve3");
        step("bnd_mid", 1'b1, LEFT + 1, 1'b0);
        step("bnd_mid2", 1'b1, RIGHT - 1, 1'b0);
        step("bnd_r", 1'b1, RIGHT, 1'b0);
        serve("serve4");

        // Player 1 wins (already holds 1 point)
        for (int g = 0; g < 8; g++) begin
            step("win_goal", 1'b1, 640, 1'b0);
            if (m_state == M_HOLD) serve("win_srv");
        end
        check("win_s1", int'(score_p1), WS);
        check("win_over", int'(game_over), 1);
        check("win_who", int'(winner), 0);

        // Ticks in GAME_OVER with ball on the left goal
        for (int t = 0; t < 10; t++) step("over_tk", 1'b1, 0, 1'b0);
`ifdef SCORE_AUTO_RESTART_EN
        check("auto_over", m_over, 0);
`else
        check("hold_over", int'(game_over), 1);
        check("hold_s2", int'(score_p2), 2);
`endif

        // Restart priority over a goal
        step("rst", 1'b0, 320, 1'b1);
        serve("serve5");
        step("rst_goal", 1'b1, 0, 1'b1);
        check("rst_goal_p2", int'(point_p2), 0);

        // Restart priority over holdoff expiry
        for (int t = 0; t < HF - 1; t++) step("rst_hold", 1'b1, 320, 1'b0);
        step("rst_exp", 1'b1, 320, 1'b1);
        check("rst_exp_sreq", int'(serve_req), 0);

        // Mid-holdoff asynchronous reset with score_p1 = 4
        step("rst2", 1'b0, 320, 1'b1);
        for (int g = 0; g < 4; g++) begin
            serve("pre4");
            step("p1_goal", 1'b1, 640, 1'b0);
        end
        step("mid_hold", 1'b1, 320, 1'b0);
        check("mid_s1", int'(score_p1), 4);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        serve("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
